// File: rtl/sprite_pkg.sv
// Shared types and screen constants for the sprite mover and its helpers.
package sprite_pkg;

    localparam int H_RES       = 640;
    localparam int V_RES       = 480;
    localparam int SPRITE_SIZE = 32;

    typedef logic [9:0] coord_t;

    // Bit order left..down maps onto the {left, right, up, down} button vector.
    typedef struct packed {
        logic left;
        logic right;
        logic up;
        logic down;
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } mover_state_t;

    // One axis step with saturation at 0 and at maxW.
    // If both directions on this axis are requested they cancel out.
    // The math uses 11 bits so cur+step cannot wrap before the clamp.
    function automatic coord_t stepCoord(
        input coord_t      cur,
        input logic        dec,
        input logic        inc,
        input logic [10:0] stepW,
        input logic [10:0] maxW
    );
        logic [10:0] wide;
        logic [10:0] sum;
        logic [10:0] res;
        wide = {1'b0, cur};
        sum  = wide + stepW;
        res  = wide;
        if (dec && !inc) begin
            res = (wide < stepW) ? 11'd0 : (wide - stepW);
        end else if (inc && !dec) begin
            res = (sum > maxW) ? maxW : sum;
        end
        return res[9:0];
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for one asynchronous button, plus a rising-edge pulse.
// level is the synchronized button state.
// pulse is high for one cycle, on the first cycle that level is high.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic pulse
);

    logic meta;
    logic sync;
    logic syncQ;

    // Resync the raw button, and keep one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            syncQ <= 1'b0;
        end else begin
            meta  <= btn;
            sync  <= meta;
            syncQ <= sync;
        end
    end

    assign level = sync;
    assign pulse = sync & ~syncQ;

endmodule

// File: rtl/sprite_mover.sv
// Sprite position owner.
// Turns async direction buttons into frame-synchronous, clamped moves of the
// sprite's top-left corner. Holding a button auto-repeats after a delay.
module sprite_mover #(
    parameter int H_RES        = sprite_pkg::H_RES,
    parameter int V_RES        = sprite_pkg::V_RES,
    parameter int SPRITE_SIZE  = sprite_pkg::SPRITE_SIZE,
    parameter int STEP         = 4,
    parameter int INIT_X       = 304,
    parameter int INIT_Y       = 224,
    parameter int REPEAT_DELAY = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vBlank,
    input  logic       enable,
    input  logic       btnLeft,
    input  logic       btnRight,
    input  logic       btnUp,
    input  logic       btnDown,
    output logic [9:0] posX,
    output logic [9:0] posY,
    output logic       isMoving
);

    import sprite_pkg::dir_t;
    import sprite_pkg::mover_state_t;
    import sprite_pkg::IDLE;
    import sprite_pkg::DELAY;
    import sprite_pkg::REPEAT;
    import sprite_pkg::stepCoord;

    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] MAX_X  = 11'(H_RES - SPRITE_SIZE);
    localparam logic [10:0] MAX_Y  = 11'(V_RES - SPRITE_SIZE);

    localparam int              CNT_W    = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_DELAY - 1);

    logic [3:0]       btnVec;
    logic [3:0]       heldVec;
    logic [3:0]       pressVec;
    logic [3:0]       pending;
    dir_t             move;
    mover_state_t     state;
    logic [CNT_W-1:0] frameCnt;
    logic             vBlankQ;
    logic             tick;
    logic             anyHeld;
    logic             anyPending;

    assign btnVec = {btnLeft, btnRight, btnUp, btnDown};

    for (genvar i = 0; i < 4; i++) begin : g_sync
        btn_sync u_sync (
            .clk   (clk),
            .rst   (rst),
            .btn   (btnVec[i]),
            .level (heldVec[i]),
            .pulse (pressVec[i])
        );
    end

    assign anyHeld    = |heldVec;
    assign anyPending = |pending;
    assign tick       = vBlank & ~vBlankQ;

    // Delay vBlank by one cycle.
    // Reset value is 1, so a vBlank already high at reset release gives no tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vBlankQ <= 1'b1;
        end else begin
            vBlankQ <= vBlank;
        end
    end

    // Collect presses between frame ticks.
    // A press on the tick cycle itself is carried into the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else if (!enable) begin
            pending <= '0;
        end else if (tick) begin
            pending <= pressVec;
        end else begin
            pending <= pending | pressVec;
        end
    end

    // Direction set for this frame: fresh presses, plus held buttons once
    // auto-repeat is running.
    always_comb begin
        move = dir_t'(pending);
        if (state == REPEAT) begin
            move = dir_t'(pending | heldVec);
        end
    end

    // Apply the frame's move on the tick edge only, so the painter never sees
    // the position change mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            posX <= 10'(INIT_X);
            posY <= 10'(INIT_Y);
        end else if (enable && tick) begin
            posX <= stepCoord(posX, move.left, move.right, STEP_W, MAX_X);
            posY <= stepCoord(posY, move.up, move.down, STEP_W, MAX_Y);
        end
    end

    // Auto-repeat controller.
    // After the first move, count held frames. Start repeating once the delay
    // has elapsed. Drop back to idle as soon as nothing is held or pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            frameCnt <= '0;
            isMoving <= 1'b0;
        end else if (!enable) begin
            state    <= IDLE;
            isMoving <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick && (move != '0)) begin
                        state    <= DELAY;
                        frameCnt <= '0;
                        isMoving <= 1'b1;
                    end
                end
                DELAY: begin
                    if (!anyHeld && !anyPending) begin
                        state    <= IDLE;
                        isMoving <= 1'b0;
                    end else if (tick && anyHeld) begin
                        if (frameCnt == CNT_LAST) begin
                            state <= REPEAT;
                        end else begin
                            frameCnt <= frameCnt + CNT_W'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (!anyHeld && !anyPending) begin
                        state    <= IDLE;
                        isMoving <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    isMoving <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_mover.sv
// Self-checking bench for sprite_mover.
// Expected positions are queued when a frame is driven, then popped and
// compared once the tick has landed.
module tb_sprite_mover;

    localparam int STEP         = 4;
    localparam int REPEAT_DELAY = 8;
    localparam int INIT_X       = 304;
    localparam int INIT_Y       = 224;
    localparam int MAX_X        = 608;
    localparam int MAX_Y        = 448;

    logic       clk = 1'b0;
    logic       rst;
    logic       vBlank;
    logic       enable;
    logic       btnLeft;
    logic       btnRight;
    logic       btnUp;
    logic       btnDown;
    logic [9:0] posX;
    logic [9:0] posY;
    logic       isMoving;

    int checks = 0;
    int errors = 0;
    int refX;
    int refY;
    int expXQ[$];
    int expYQ[$];

    sprite_mover dut (
        .clk      (clk),
        .rst      (rst),
        .vBlank   (vBlank),
        .enable   (enable),
        .btnLeft  (btnLeft),
        .btnRight (btnRight),
        .btnUp    (btnUp),
        .btnDown  (btnDown),
        .posX     (posX),
        .posY     (posY),
        .isMoving (isMoving)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One frame: vBlank low for 3 cycles, then it rises.
    // Returns on the negedge right after the tick edge.
    task automatic doTick();
        vBlank = 1'b0;
        waitCycles(3);
        vBlank = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int ex;
        rst = 1'b1; vBlank = 1'b1; enable = 1'b1;
        btnLeft = 1'b0; btnRight = 1'b0; btnUp = 1'b0; btnDown = 1'b0;
        waitCycles(3);
        checks++; if (posX !== 10'(INIT_X)) begin errors++; $display("[TB] FAIL reset_posX: got %0d, expected %0d", posX, INIT_X); end
        checks++; if (posY !== 10'(INIT_Y)) begin errors++; $display("[TB] FAIL reset_posY: got %0d, expected %0d", posY, INIT_Y); end
        checks++; if (isMoving !== 1'b0) begin errors++; $display("[TB] FAIL reset_isMoving: got %b, expected 0", isMoving); end
        // Release with vBlank already high; a press must wait for a real rising edge.
        rst = 1'b0;
        btnRight = 1'b1;
        waitCycles(6);
        btnRight = 1'b0;
        waitCycles(6);
        checks++; if (posX !== 10'(INIT_X)) begin errors++; $display("[TB] FAIL vblank_high_at_release: got %0d, expected %0d", posX, INIT_X); end
        refX = INIT_X + STEP;
        refY = INIT_Y;
        expXQ.push_back(refX);
        doTick();
        ex = expXQ.pop_front();
        checks++; if (posX !== 10'(ex)) begin errors++; $display("[TB] FAIL first_real_tick: got %0d, expected %0d", posX, ex); end
        waitCycles(4);
        checks++; if (isMoving !== 1'b0) begin errors++; $display("[TB] FAIL first_tick_idle: got %b, expected 0", isMoving); end
    endtask

    task automatic test_tap();
        int ex;
        btnRight = 1'b1;
        waitCycles(10);
        btnRight = 1'b0;
        waitCycles(2);
        checks++; if (posX !== 10'(refX)) begin errors++; $display("[TB] FAIL tap_stable_before_tick: got %0d, expected %0d", posX, refX); end
        refX = refX + STEP;
        for (int k = 0; k < 6; k++) expXQ.push_back(refX);
        for (int k = 0; k < 6; k++) begin
            doTick();
            ex = expXQ.pop_front();
            checks++; if (posX !== 10'(ex)) begin errors++; $display("[TB] FAIL tap_tick%0d: got %0d, expected %0d", k, posX, ex); end
        end
        checks++; if (isMoving !== 1'b0) begin errors++; $display("[TB] FAIL tap_idle: got %b, expected 0", isMoving); end
    endtask

    task automatic test_hold();
        int ex;
        int ey;
        btnLeft = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            if (k == 1 || k >= REPEAT_DELAY + 2) refX = (refX < STEP) ? 0 : refX - STEP;
            expXQ.push_back(refX);
            expYQ.push_back(refY);
            doTick();
            ex = expXQ.pop_front();
            ey = expYQ.pop_front();
            checks++; if (posX !== 10'(ex)) begin errors++; $display("[TB] FAIL hold_x_tick%0d: got %0d, expected %0d", k, posX, ex); end
            checks++; if (posY !== 10'(ey)) begin errors++; $display("[TB] FAIL hold_y_tick%0d: got %0d, expected %0d", k, posY, ey); end
            checks++; if (isMoving !== 1'b1) begin errors++; $display("[TB] FAIL hold_moving_tick%0d: got %b, expected 1", k, isMoving); end
        end
        btnLeft = 1'b0;
        waitCycles(5);
        checks++; if (isMoving !== 1'b0) begin errors++; $display("[TB] FAIL hold_release_idle: got %b, expected 0", isMoving); end
    endtask

    task automatic test_clamp_left();
        int ex;
        btnLeft = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            if (k == 1 || k >= REPEAT_DELAY + 2) refX = (refX < STEP) ? 0 : refX - STEP;
            expXQ.push_back(refX);
            doTick();
            ex = expXQ.pop_front();
            checks++; if (posX !== 10'(ex)) begin errors++; $display("[TB] FAIL clamp_left_tick%0d: got %0d, expected %0d", k, posX, ex); end
        end
        btnLeft = 1'b0;
        waitCycles(5);
        checks++; if (posX !== 10'd0) begin errors++; $display("[TB] FAIL clamp_left_final: got %0d, expected 0", posX); end
    endtask

    task automatic test_clamp_right_down();
        int ex;
        int ey;
        btnRight = 1'b1;
        btnDown  = 1'b1;
        for (int k = 1; k <= 170; k++) begin
            if (k == 1 || k >= REPEAT_DELAY + 2) begin
                refX = (refX + STEP > MAX_X) ? MAX_X : refX + STEP;
                refY = (refY + STEP > MAX_Y) ? MAX_Y : refY + STEP;
            end
            expXQ.push_back(refX);
            expYQ.push_back(refY);
            doTick();
            ex = expXQ.pop_front();
            ey = expYQ.pop_front();
            checks++; if (posX !== 10'(ex)) begin errors++; $display("[TB] FAIL clamp_right_tick%0d: got %0d, expected %0d", k, posX, ex); end
            checks++; if (posY !== 10'(ey)) begin errors++; $display("[TB] FAIL clamp_down_tick%0d: got %0d, expected %0d", k, posY, ey); end
        end
        btnRight = 1'b0;
        btnDown  = 1'b0;
        waitCycles(5);
        checks++; if (isMoving !== 1'b0) begin errors++; $display("[TB] FAIL clamp_release_idle: got %b, expected 0", isMoving); end
    endtask

    task automatic test_conflict();
        int ex;
        int ey;
        btnLeft = 1'b1; btnRight = 1'b1; btnUp = 1'b1;
        waitCycles(6);
        btnLeft = 1'b0; btnRight = 1'b0; btnUp = 1'b0;
        refY = refY - STEP;
        expXQ.push_back(refX);
        expYQ.push_back(refY);
        doTick();
        ex = expXQ.pop_front();
        ey = expYQ.pop_front();
        checks++; if (posX !== 10'(ex)) begin errors++; $display("[TB] FAIL conflict_x: got %0d, expected %0d", posX, ex); end
        checks++; if (posY !== 10'(ey)) begin errors++; $display("[TB] FAIL conflict_y: got %0d, expected %0d", posY, ey); end
        waitCycles(4);
    endtask

    task automatic test_enable();
        int ey;
        // Press, then drop enable before the tick: the press is discarded.
        btnDown = 1'b1;
        waitCycles(4);
        btnDown = 1'b0;
        waitCycles(2);
        enable = 1'b0;
        waitCycles(2);
        enable = 1'b1;
        expYQ.push_back(refY);
        doTick();
        ey = expYQ.pop_front();
        checks++; if (posY !== 10'(ey)) begin errors++; $display("[TB] FAIL enable_cleared_press: got %0d, expected %0d", posY, ey); end
        checks++; if (isMoving !== 1'b0) begin errors++; $display("[TB] FAIL enable_stays_idle: got %b, expected 0", isMoving); end
        // Tick while disabled: no move, and nothing carried over afterwards.
        btnDown = 1'b1;
        waitCycles(4);
        btnDown = 1'b0;
        enable = 1'b0;
        expYQ.push_back(refY);
        doTick();
        ey = expYQ.pop_front();
        checks++; if (posY !== 10'(ey)) begin errors++; $display("[TB] FAIL enable_low_tick: got %0d, expected %0d", posY, ey); end
        enable = 1'b1;
        expYQ.push_back(refY);
        doTick();
        ey = expYQ.pop_front();
        checks++; if (posY !== 10'(ey)) begin errors++; $display("[TB] FAIL enable_no_carry: got %0d, expected %0d", posY, ey); end
    endtask

    task automatic test_back_to_back();
        int ex;
        int ey;
        btnLeft = 1'b1;
        waitCycles(4);
        btnLeft = 1'b0;
        refX = refX - STEP;
        expXQ.push_back(refX); expYQ.push_back(refY);
        refY = refY - STEP;
        expXQ.push_back(refX); expYQ.push_back(refY);
        // The up press reaches its edge detector exactly on the tick cycle.
        fork
            doTick();
            begin
                waitCycles(1);
                btnUp = 1'b1;
            end
        join
        ex = expXQ.pop_front();
        ey = expYQ.pop_front();
        checks++; if (posX !== 10'(ex)) begin errors++; $display("[TB] FAIL b2b_tick1_x: got %0d, expected %0d", posX, ex); end
        checks++; if (posY !== 10'(ey)) begin errors++; $display("[TB] FAIL b2b_tick1_y: got %0d, expected %0d", posY, ey); end
        waitCycles(3);
        btnUp = 1'b0;
        doTick();
        ex = expXQ.pop_front();
        ey = expYQ.pop_front();
        checks++; if (posX !== 10'(ex)) begin errors++; $display("[TB] FAIL b2b_tick2_x: got %0d, expected %0d", posX, ex); end
        checks++; if (posY !== 10'(ey)) begin errors++; $display("[TB] FAIL b2b_tick2_y: got %0d, expected %0d", posY, ey); end
        waitCycles(5);
    endtask

    task automatic test_reset_repeat();
        int ex;
        btnLeft = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (k == 1 || k >= REPEAT_DELAY + 2) refX = (refX < STEP) ? 0 : refX - STEP;
            expXQ.push_back(refX);
            doTick();
            ex = expXQ.pop_front();
            checks++; if (posX !== 10'(ex)) begin errors++; $display("[TB] FAIL rr_tick%0d: got %0d, expected %0d", k, posX, ex); end
        end
        checks++; if (isMoving !== 1'b1) begin errors++; $display("[TB] FAIL rr_moving: got %b, expected 1", isMoving); end
        // Assert reset between clock edges; the outputs must change at once.
        #2;
        rst = 1'b1;
        #1;
        checks++; if (posX !== 10'(INIT_X)) begin errors++; $display("[TB] FAIL rr_async_posX: got %0d, expected %0d", posX, INIT_X); end
        checks++; if (posY !== 10'(INIT_Y)) begin errors++; $display("[TB] FAIL rr_async_posY: got %0d, expected %0d", posY, INIT_Y); end
        checks++; if (isMoving !== 1'b0) begin errors++; $display("[TB] FAIL rr_async_isMoving: got %b, expected 0", isMoving); end
        @(negedge clk);
        rst = 1'b0;
        btnLeft = 1'b0;
        refX = INIT_X;
        refY = INIT_Y;
        waitCycles(3);
        btnRight = 1'b1;
        waitCycles(4);
        btnRight = 1'b0;
        refX = refX + STEP;
        expXQ.push_back(refX);
        doTick();
        ex = expXQ.pop_front();
        checks++; if (posX !== 10'(ex)) begin errors++; $display("[TB] FAIL rr_after_reset: got %0d, expected %0d", posX, ex); end
    endtask

    initial begin
        $display("[TB] sprite_mover bench start");
        test_reset();
        test_tap();
        test_hold();
        test_clamp_left();
        test_clamp_right_down();
        test_conflict();
        test_enable();
        test_back_to_back();
        test_reset_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
